uart_user_echo: RTL and testbench
=================================

Name: uart_user_echo

Overview:
- User-side responder for the UART driver's byte stream.
- Consumes bytes arriving on the driver's receive output (valid-only, no backpressure) and buffers them in a FIFO. When echo is enabled, it replays them on the driver's transmit valid/ready input.
- An optional sequence checker confirms that received bytes increment by one modulo 2^P_DATA_WIDTH, so a board or loopback link can be soaked unattended.

Parameters:
- P_DATA_WIDTH, 8, user data width; must match the UART data width.
- P_FIFO_DEPTH, 16, echo FIFO depth; power of two, at least 2.
- P_SEQ_CHECK, 1, 1 enables the incrementing-sequence checker; 0 holds o_seq_err_cnt at 0.
- P_CNT_WIDTH, 16, width of all status counters.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  synchronous reset, active-low.
- i_echo_en  in  1  1 pushes received bytes into the FIFO; 0 makes the block a counting/checking sink only.
- i_user_rx_data  in  P_DATA_WIDTH  received byte from the UART driver.
- i_user_rx_valid  in  1  single-cycle strobe qualifying i_user_rx_data.
- o_user_tx_data  out  P_DATA_WIDTH  byte to transmit.
- o_user_tx_valid  out  1  o_user_tx_data is valid.
- i_user_tx_ready  in  1  driver can accept a byte.
- o_fifo_level  out  $clog2(P_FIFO_DEPTH)+1  current FIFO occupancy.
- o_rx_cnt  out  P_CNT_WIDTH  received bytes, saturating.
- o_tx_cnt  out  P_CNT_WIDTH  transmitted bytes, saturating.
- o_ovf_cnt  out  P_CNT_WIDTH  bytes dropped on a full FIFO, saturating.
- o_seq_err_cnt  out  P_CNT_WIDTH  sequence mismatches, saturating.

Behaviour:
- Reset: when i_rst_n=0 at a clock edge, all of the following clear at that edge:
  - o_user_tx_valid=0, o_user_tx_data=0, o_fifo_level=0;
  - all counters to 0;
  - FIFO pointers to 0, checker "armed" flag to 0.
  - Any pending tx handshake is abandoned; reset mid-transfer leaves no residue.
- Transfer rule: a tx transfer occurs on an edge where o_user_tx_valid=1 and i_user_tx_ready=1.
  - While o_user_tx_valid=1 and no transfer has occurred, o_user_tx_data must stay stable.
  - o_user_tx_valid must not deassert before its transfer.
- Output stage: o_user_tx_valid/o_user_tx_data are registered and fed from the FIFO head.
  - Latency: a byte pushed into an empty FIFO at edge N appears with valid=1 at edge N+1. Zero-cycle passthrough is not allowed.
  - After a transfer, the next byte (if any) is presented on the following edge. Sustained throughput is one byte per cycle when ready stays high.
- Push: a push occurs when i_user_rx_valid=1 and i_echo_en=1.
  - It is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and o_ovf_cnt increments.
  - Data is never overwritten.
- Simultaneous push and pop: occupancy is unchanged. Pointers wrap modulo P_FIFO_DEPTH.
- Level accounting: o_fifo_level counts every byte held, including the one in the output register. It ranges 0..P_FIFO_DEPTH.
- i_echo_en: sampled each cycle.
  - Deasserting it stops new pushes only; bytes already queued still drain.
  - While i_echo_en=0, o_rx_cnt and the checker still update.
- Counters:
  - o_rx_cnt increments on every i_user_rx_valid.
  - o_tx_cnt increments on every transfer.
  - All counters saturate at all-ones and never wrap.
- Sequence checker (P_SEQ_CHECK=1), acting on every received byte (accepted or dropped). States: IDLE (unarmed) and TRACK.
  - IDLE: the first byte sets expected = byte+1 (mod 2^P_DATA_WIDTH); move to TRACK; no error is counted.
  - TRACK: if the byte differs from expected, o_seq_err_cnt increments. In both cases expected then becomes byte+1, so the checker resyncs on the next byte.
  - Wrap: 0xFF followed by 0x00 is correct for P_DATA_WIDTH=8.
- Back-to-back rx valid strobes on consecutive cycles must be handled. The driver does not produce them, but the bench may.

Test Plan:
- Loopback run: reset low 5 cycles, i_echo_en=1, tx_ready always 1, feed rx bytes 0x00..0x0F one every 10 cycles -> tx emits 0x00..0x0F in order, each 1 cycle after its push; o_rx_cnt=o_tx_cnt=16, o_seq_err_cnt=0, o_ovf_cnt=0.
- Overflow: tx_ready=0, push 20 bytes 0x00..0x13 with depth 16 -> o_fifo_level=16, o_ovf_cnt=4. Then release ready -> tx emits exactly 0x00..0x0F while data stays stable during stall; o_seq_err_cnt=0.
- Full with simultaneous pop: FIFO full, ready=1 and rx_valid in the same cycle -> byte accepted, level stays 16, o_ovf_cnt unchanged.
- Sequence error and wrap: rx bytes 0xFE,0xFF,0x00,0x05,0x06 -> o_seq_err_cnt=1 (at 0x05 only), o_rx_cnt=5.
- Sink mode: i_echo_en=0, push 8 bytes -> o_user_tx_valid stays 0, level 0, o_rx_cnt=8. Toggle i_echo_en=1 with 3 bytes queued earlier then cleared -> queued bytes drain.
- Reset mid-stream: assert i_rst_n=0 while valid=1 and ready=0 with 5 bytes queued -> next edge valid=0, level=0, all counters 0. First byte after reset re-arms the checker without an error.

Source files
------------

// File: rtl/uart_user_echo.sv
// ---------------------------------------------------------------------------
// uart_user_echo
//
// User-side responder for a UART driver byte stream. Received bytes are
// counted, optionally checked for an incrementing sequence, and (when echo is
// enabled) queued in a FIFO and replayed on a valid/ready transmit interface.
//
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_echo_en           1: push received bytes into the echo FIFO
//   i_user_rx_data/valid  received byte and its single-cycle strobe
//   o_user_tx_data/valid, i_user_tx_ready  registered transmit handshake
//   o_fifo_level        bytes held, including the one in the output register
//   o_rx_cnt, o_tx_cnt, o_ovf_cnt, o_seq_err_cnt  saturating status counters
// ---------------------------------------------------------------------------
module uart_user_echo #(
    parameter int unsigned P_DATA_WIDTH = 8,
    parameter int unsigned P_FIFO_DEPTH = 16,
    parameter int unsigned P_SEQ_CHECK  = 1,
    parameter int unsigned P_CNT_WIDTH  = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_echo_en,
    input  logic [P_DATA_WIDTH-1:0]           i_user_rx_data,
    input  logic                              i_user_rx_valid,
    output logic [P_DATA_WIDTH-1:0]           o_user_tx_data,
    output logic                              o_user_tx_valid,
    input  logic                              i_user_tx_ready,
    output logic [$clog2(P_FIFO_DEPTH):0]     o_fifo_level,
    output logic [P_CNT_WIDTH-1:0]            o_rx_cnt,
    output logic [P_CNT_WIDTH-1:0]            o_tx_cnt,
    output logic [P_CNT_WIDTH-1:0]            o_ovf_cnt,
    output logic [P_CNT_WIDTH-1:0]            o_seq_err_cnt
);

    localparam int unsigned LP_PTR_W = $clog2(P_FIFO_DEPTH);
    localparam int unsigned LP_LVL_W = LP_PTR_W + 1;

    localparam logic [LP_LVL_W-1:0]     LP_LVL_FULL = LP_LVL_W'(P_FIFO_DEPTH);
    localparam logic [LP_LVL_W-1:0]     LP_LVL_ONE  = LP_LVL_W'(1);
    localparam logic [LP_LVL_W-1:0]     LP_LVL_ZERO = '0;
    localparam logic [LP_PTR_W-1:0]     LP_PTR_ONE  = LP_PTR_W'(1);
    localparam logic [P_DATA_WIDTH-1:0] LP_DATA_ONE = P_DATA_WIDTH'(1);
    localparam logic [P_CNT_WIDTH-1:0]  LP_CNT_ONE  = P_CNT_WIDTH'(1);
    localparam logic [P_CNT_WIDTH-1:0]  LP_CNT_MAX  = '1;

    // Sequence checker states
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_TRACK = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [P_DATA_WIDTH-1:0] r_mem [P_FIFO_DEPTH];
    logic [LP_PTR_W-1:0]     r_wr_ptr;
    logic [LP_PTR_W-1:0]     r_rd_ptr;
    logic [LP_LVL_W-1:0]     r_mem_cnt;   // bytes in memory only
    logic [LP_LVL_W-1:0]     r_level;     // memory plus output register
    logic                    r_tx_valid;
    logic [P_DATA_WIDTH-1:0] r_tx_data;
    logic [P_CNT_WIDTH-1:0]  r_rx_cnt;
    logic [P_CNT_WIDTH-1:0]  r_tx_cnt;
    logic [P_CNT_WIDTH-1:0]  r_ovf_cnt;
    logic [P_CNT_WIDTH-1:0]  r_seq_err_cnt;
    logic [0:0]              r_seq_state;
    logic [P_DATA_WIDTH-1:0] r_expected;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic w_pop;
    logic w_push_req;
    logic w_full;
    logic w_push;
    logic w_drop;
    logic w_load;
    logic w_seq_err;

    assign w_pop      = r_tx_valid & i_user_tx_ready;
    assign w_push_req = i_user_rx_valid & i_echo_en;
    assign w_full     = (r_level == LP_LVL_FULL);
    // A full FIFO still accepts when the output register empties this cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & ~w_push;
    // Output register reloads only from memory contents present before this
    // edge, so a fresh push is never passed straight through.
    assign w_load     = (r_mem_cnt != LP_LVL_ZERO) & (~r_tx_valid | w_pop);
    assign w_seq_err  = (P_SEQ_CHECK != 0) & i_user_rx_valid &
                        (r_seq_state == S_TRACK) & (i_user_rx_data != r_expected);

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed; pointers define validity)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push) begin
            r_mem[r_wr_ptr] <= i_user_rx_data;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and output register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_level    <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end

            case ({w_push, w_load})
                2'b10:   r_mem_cnt <= r_mem_cnt + LP_LVL_ONE;
                2'b01:   r_mem_cnt <= r_mem_cnt - LP_LVL_ONE;
                default: r_mem_cnt <= r_mem_cnt;
            endcase

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LP_LVL_ONE;
                2'b01:   r_level <= r_level - LP_LVL_ONE;
                default: r_level <= r_level;
            endcase

            if (w_load) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= r_mem[r_rd_ptr];
            end else if (w_pop) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating status counters
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rx_cnt      <= '0;
            r_tx_cnt      <= '0;
            r_ovf_cnt     <= '0;
            r_seq_err_cnt <= '0;
        end else begin
            if (i_user_rx_valid && (r_rx_cnt != LP_CNT_MAX)) begin
                r_rx_cnt <= r_rx_cnt + LP_CNT_ONE;
            end
            if (w_pop && (r_tx_cnt != LP_CNT_MAX)) begin
                r_tx_cnt <= r_tx_cnt + LP_CNT_ONE;
            end
            if (w_drop && (r_ovf_cnt != LP_CNT_MAX)) begin
                r_ovf_cnt <= r_ovf_cnt + LP_CNT_ONE;
            end
            if (w_seq_err && (r_seq_err_cnt != LP_CNT_MAX)) begin
                r_seq_err_cnt <= r_seq_err_cnt + LP_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequence checker: sees every received byte, accepted or dropped.
    // Expected value always resyncs to byte+1, so one bad byte costs one error.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_seq_state <= S_IDLE;
            r_expected  <= '0;
        end else if (i_user_rx_valid) begin
            r_seq_state <= S_TRACK;
            r_expected  <= i_user_rx_data + LP_DATA_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_user_tx_data  = r_tx_data;
    assign o_user_tx_valid = r_tx_valid;
    assign o_fifo_level    = r_level;
    assign o_rx_cnt        = r_rx_cnt;
    assign o_tx_cnt        = r_tx_cnt;
    assign o_ovf_cnt       = r_ovf_cnt;
    assign o_seq_err_cnt   = r_seq_err_cnt;

endmodule

// File: tb/tb_uart_user_echo.sv
// ---------------------------------------------------------------------------
// tb_uart_user_echo
//
// Directed bench for uart_user_echo with hand-computed expectations:
// loopback, overflow/stall, full-with-pop, sequence errors and wrap, sink
// mode with drain, and reset mid-stream.
// ---------------------------------------------------------------------------
module tb_uart_user_echo;

    logic        clk;
    logic        rst_n;
    logic        echo_en;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [4:0]  fifo_level;
    logic [15:0] rx_cnt;
    logic [15:0] tx_cnt;
    logic [15:0] ovf_cnt;
    logic [15:0] seq_err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    uart_user_echo #(
        .P_DATA_WIDTH (8),
        .P_FIFO_DEPTH (16),
        .P_SEQ_CHECK  (1),
        .P_CNT_WIDTH  (16)
    ) u_dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_echo_en       (echo_en),
        .i_user_rx_data  (rx_data),
        .i_user_rx_valid (rx_valid),
        .o_user_tx_data  (tx_data),
        .o_user_tx_valid (tx_valid),
        .i_user_tx_ready (tx_ready),
        .o_fifo_level    (fifo_level),
        .o_rx_cnt        (rx_cnt),
        .o_tx_cnt        (tx_cnt),
        .o_ovf_cnt       (ovf_cnt),
        .o_seq_err_cnt   (seq_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Advance one edge; inputs driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check_counters(input string tag, input int rx, input int tx,
                                  input int ovf, input int serr);
        check_eq({tag, ".rx_cnt"},  32'(rx_cnt),      32'(rx));
        check_eq({tag, ".tx_cnt"},  32'(tx_cnt),      32'(tx));
        check_eq({tag, ".ovf_cnt"}, 32'(ovf_cnt),     32'(ovf));
        check_eq({tag, ".seq_err"}, 32'(seq_err_cnt), 32'(serr));
    endtask

    initial begin
        logic [7:0] seq_bytes [5];
        int         seq_errs  [5];

        rst_n    = 1'b0;
        echo_en  = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;

        // ---------------- reset state ----------------
        do_reset();
        check_eq("rst.valid", 32'(tx_valid),   32'd0);
        check_eq("rst.data",  32'(tx_data),    32'd0);
        check_eq("rst.level", 32'(fifo_level), 32'd0);
        check_counters("rst", 0, 0, 0, 0);

        // ---------------- loopback ----------------
        echo_en  = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            check_eq("lb.push_valid", 32'(tx_valid),   32'd0);
            check_eq("lb.push_level", 32'(fifo_level), 32'd1);
            tick();
            check_eq("lb.out_valid",  32'(tx_valid),   32'd1);
            check_eq("lb.out_data",   32'(tx_data),    32'(i));
            check_eq("lb.out_level",  32'(fifo_level), 32'd1);
            tick();
            check_eq("lb.done_valid", 32'(tx_valid),   32'd0);
            check_eq("lb.done_level", 32'(fifo_level), 32'd0);
            repeat (7) tick();
        end
        check_counters("lb", 16, 16, 0, 0);

        // ---------------- overflow, stall, full with pop ----------------
        do_reset();
        echo_en  = 1'b1;
        tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rx_data  = 8'(i);
            rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        tick();
        check_eq("ovf.level", 32'(fifo_level), 32'd16);
        check_eq("ovf.valid", 32'(tx_valid),   32'd1);
        check_eq("ovf.data",  32'(tx_data),    32'h00);
        check_counters("ovf", 20, 0, 4, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall.valid", 32'(tx_valid), 32'd1);
            check_eq("stall.data",  32'(tx_data),  32'h00);
        end
        // Full FIFO: pop and push on the same edge; 0x14 keeps the sequence.
        tx_ready = 1'b1;
        rx_data  = 8'h14;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check_eq("fullpop.level", 32'(fifo_level), 32'd16);
        check_eq("fullpop.data",  32'(tx_data),    32'h01);
        check_counters("fullpop", 21, 1, 4, 0);
        for (int k = 2; k < 16; k++) begin
            tick();
            check_eq("drain.data",  32'(tx_data),  32'(k));
            check_eq("drain.valid", 32'(tx_valid), 32'd1);
        end
        tick();
        check_eq("drain.last", 32'(tx_data), 32'h14);
        tick();
        check_eq("drain.end_valid", 32'(tx_valid),   32'd0);
        check_eq("drain.end_level", 32'(fifo_level), 32'd0);
        check_counters("drain", 21, 17, 4, 0);

        // ---------------- sequence error and wrap ----------------
        do_reset();
        echo_en      = 1'b0;
        seq_bytes[0] = 8'hFE; seq_errs[0] = 0;
        seq_bytes[1] = 8'hFF; seq_errs[1] = 0;
        seq_bytes[2] = 8'h00; seq_errs[2] = 0;
        seq_bytes[3] = 8'h05; seq_errs[3] = 1;
        seq_bytes[4] = 8'h06; seq_errs[4] = 1;
        for (int i = 0; i < 5; i++) begin
            send_byte(seq_bytes[i]);
            check_eq("seq.err", 32'(seq_err_cnt), 32'(seq_errs[i]));
            tick();
        end
        check_eq("seq.rx_cnt", 32'(rx_cnt), 32'd5);

        // ---------------- sink mode, then drain ----------------
        do_reset();
        echo_en  = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i));
            check_eq("sink.valid", 32'(tx_valid),   32'd0);
            check_eq("sink.level", 32'(fifo_level), 32'd0);
        end
        check_counters("sink", 8, 0, 0, 0);
        echo_en  = 1'b1;
        tx_ready = 1'b0;
        for (int i = 8; i < 11; i++) begin
            send_byte(8'(i));
        end
        echo_en = 1'b0;
        send_byte(8'h0B);   // counted but not queued
        tick();
        check_eq("sinkq.level", 32'(fifo_level), 32'd3);
        check_eq("sinkq.data",  32'(tx_data),    32'h08);
        tx_ready = 1'b1;
        tick();
        check_eq("sinkq.d1", 32'(tx_data), 32'h09);
        tick();
        check_eq("sinkq.d2", 32'(tx_data), 32'h0A);
        tick();
        check_eq("sinkq.end_valid", 32'(tx_valid),   32'd0);
        check_eq("sinkq.end_level", 32'(fifo_level), 32'd0);
        check_counters("sinkq", 12, 3, 0, 0);

        // ---------------- reset mid-stream ----------------
        do_reset();
        echo_en  = 1'b1;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(8'h20 + i));
        end
        tick();
        check_eq("mid.level", 32'(fifo_level), 32'd5);
        check_eq("mid.valid", 32'(tx_valid),   32'd1);
        check_eq("mid.data",  32'(tx_data),    32'h20);
        rst_n = 1'b0;
        tick();
        check_eq("mid.rst_valid", 32'(tx_valid),   32'd0);
        check_eq("mid.rst_level", 32'(fifo_level), 32'd0);
        check_eq("mid.rst_data",  32'(tx_data),    32'd0);
        check_counters("mid.rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        send_byte(8'h77);
        check_eq("rearm.err0", 32'(seq_err_cnt), 32'd0);
        check_eq("rearm.rx",   32'(rx_cnt),      32'd1);
        send_byte(8'h78);
        check_eq("rearm.err1", 32'(seq_err_cnt), 32'd0);
        send_byte(8'h10);
        check_eq("rearm.err2", 32'(seq_err_cnt), 32'd1);
        tick();
        check_eq("rearm.level", 32'(fifo_level), 32'd3);
        check_eq("rearm.data",  32'(tx_data),    32'h77);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
